// File: rtl/nvdla_dbb_rd_packer.sv
// Read-return packer: gathers MEM_DW/32 streamer words into one DBB beat with ID/LAST.
// Optional sticky protocol-error flag is built only when NVDLA_DBB_RD_PACKER_ERR_EN is defined.
module nvdla_dbb_rd_packer #(
   parameter int MEM_DW = 64,
   parameter int ID_W   = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clear_i,
   input  logic              start_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [ID_W-1:0]   id_i,
   input  logic              word_valid_i,
   output logic              word_ready_o,
   input  logic [31:0]       word_data_i,
   output logic              beat_valid_o,
   input  logic              beat_ready_i,
   output logic [MEM_DW-1:0] beat_data_o,
   output logic [ID_W-1:0]   beat_id_o,
   output logic              beat_last_o,
   output logic              idle_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int RATIO = MEM_DW / 32;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PACK,
      ST_DRAIN
   } state_t;

   state_t            state_reg, state_next;
   logic [LEN_W-1:0]  len_reg;
   logic [ID_W-1:0]   id_reg;
   logic [IDX_W-1:0]  word_idx_reg;
   logic [LEN_W:0]    beat_cnt_reg;

   logic              beat_valid_reg;
   logic [MEM_DW-1:0] beat_data_reg;
   logic [ID_W-1:0]   beat_id_reg;
   logic              beat_last_reg;

   logic              word_fire;
   logic              beat_load;
   logic              beat_is_last;
   logic              beat_fire;
   logic              start_accept;
   logic [MEM_DW-1:0] load_data;

   // Words belonging to the current beat stall only when the out reg cannot take the beat.
   assign word_ready_o = (state_reg == ST_PACK) &&
                         ((word_idx_reg != LAST_IDX) || !beat_valid_reg || beat_ready_i);
   assign word_fire    = word_valid_i && word_ready_o;
   assign beat_load    = word_fire && (word_idx_reg == LAST_IDX);
   assign beat_is_last = (beat_cnt_reg == {1'b0, len_reg});
   assign beat_fire    = beat_valid_reg && beat_ready_i;
   assign start_accept = start_i && (state_reg == ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_IDLE;
      end else if (clear_i) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_i) state_next = ST_PACK;
         end
         ST_PACK: begin
            if (beat_load && beat_is_last) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (beat_fire) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_reg      <= '0;
         id_reg       <= '0;
         word_idx_reg <= '0;
         beat_cnt_reg <= '0;
      end else if (clear_i) begin
         len_reg      <= '0;
         id_reg       <= '0;
         word_idx_reg <= '0;
         beat_cnt_reg <= '0;
      end else if (start_accept) begin
         len_reg      <= len_i;
         id_reg       <= id_i;
         word_idx_reg <= '0;
         beat_cnt_reg <= '0;
      end else if (word_fire) begin
         word_idx_reg <= (word_idx_reg == LAST_IDX) ? '0 : word_idx_reg + IDX_W'(1);
         if (beat_load) beat_cnt_reg <= beat_cnt_reg + (LEN_W+1)'(1);
      end
   end

   // Lower words are parked here; the final word of a beat bypasses straight into the out reg.
   generate
      if (RATIO > 1) begin : g_pack
         logic [31:0] pack_word_reg [RATIO-1];
         for (genvar gi = 0; gi < RATIO - 1; gi++) begin : g_word
            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  pack_word_reg[gi] <= '0;
               end else if (clear_i) begin
                  pack_word_reg[gi] <= '0;
               end else if (word_fire && (word_idx_reg == IDX_W'(gi))) begin
                  pack_word_reg[gi] <= word_data_i;
               end
            end
            assign load_data[32*gi +: 32] = pack_word_reg[gi];
         end
         assign load_data[MEM_DW-1 -: 32] = word_data_i;
      end else begin : g_nopack
         assign load_data = word_data_i;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_valid_reg <= 1'b0;
         beat_data_reg  <= '0;
         beat_id_reg    <= '0;
         beat_last_reg  <= 1'b0;
      end else if (clear_i) begin
         beat_valid_reg <= 1'b0;
         beat_data_reg  <= '0;
         beat_id_reg    <= '0;
         beat_last_reg  <= 1'b0;
      end else if (beat_load) begin
         beat_valid_reg <= 1'b1;
         beat_data_reg  <= load_data;
         beat_id_reg    <= id_reg;
         beat_last_reg  <= beat_is_last;
      end else if (beat_fire) begin
         beat_valid_reg <= 1'b0;
      end
   end

   assign beat_valid_o = beat_valid_reg;
   assign beat_data_o  = beat_data_reg;
   assign beat_id_o    = beat_id_reg;
   assign beat_last_o  = beat_last_reg;
   assign idle_o       = (state_reg == ST_IDLE);
   assign done_o       = (state_reg == ST_DRAIN) && beat_fire;

`ifdef NVDLA_DBB_RD_PACKER_ERR_EN
   logic err_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_reg <= 1'b0;
      end else if (clear_i) begin
         err_reg <= 1'b0;
      end else if ((start_i && (state_reg != ST_IDLE)) ||
                   (word_valid_i && (state_reg != ST_PACK))) begin
         err_reg <= 1'b1;
      end
   end

   assign err_o = err_reg;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_nvdla_dbb_rd_packer.sv
// Directed bench for nvdla_dbb_rd_packer: a 64-bit instance and a 32-bit (RATIO=1) instance.
module tb_nvdla_dbb_rd_packer;

`ifdef NVDLA_DBB_RD_PACKER_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic clear_i = 1'b0;

   logic        a_start = 1'b0, a_wvalid = 1'b0, a_wready, a_bvalid, a_bready = 1'b0;
   logic [7:0]  a_len = '0, a_id = '0, a_bid;
   logic [31:0] a_wdata = '0;
   logic [63:0] a_bdata;
   logic        a_blast, a_idle, a_done, a_err;

   logic        b_start = 1'b0, b_wvalid = 1'b0, b_wready, b_bvalid, b_bready = 1'b0;
   logic [7:0]  b_len = '0, b_id = '0, b_bid;
   logic [31:0] b_wdata = '0;
   logic [31:0] b_bdata;
   logic        b_blast, b_idle, b_done, b_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_i = ~clk_i;

   nvdla_dbb_rd_packer #(.MEM_DW(64), .ID_W(8), .LEN_W(8)) u_dut64 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .start_i(a_start), .len_i(a_len), .id_i(a_id),
      .word_valid_i(a_wvalid), .word_ready_o(a_wready), .word_data_i(a_wdata),
      .beat_valid_o(a_bvalid), .beat_ready_i(a_bready), .beat_data_o(a_bdata),
      .beat_id_o(a_bid), .beat_last_o(a_blast),
      .idle_o(a_idle), .done_o(a_done), .err_o(a_err)
   );

   nvdla_dbb_rd_packer #(.MEM_DW(32), .ID_W(8), .LEN_W(8)) u_dut32 (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .start_i(b_start), .len_i(b_len), .id_i(b_id),
      .word_valid_i(b_wvalid), .word_ready_o(b_wready), .word_data_i(b_wdata),
      .beat_valid_o(b_bvalid), .beat_ready_i(b_bready), .beat_data_o(b_bdata),
      .beat_id_o(b_bid), .beat_last_o(b_blast),
      .idle_o(b_idle), .done_o(b_done), .err_o(b_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_a_reset(input string tag);
      check({tag, " bvalid"}, {63'd0, a_bvalid}, 64'd0);
      check({tag, " bdata"},  a_bdata, 64'd0);
      check({tag, " bid"},    {56'd0, a_bid}, 64'd0);
      check({tag, " blast"},  {63'd0, a_blast}, 64'd0);
      check({tag, " wready"}, {63'd0, a_wready}, 64'd0);
      check({tag, " done"},   {63'd0, a_done}, 64'd0);
      check({tag, " idle"},   {63'd0, a_idle}, 64'd1);
      check({tag, " err"},    {63'd0, a_err}, 64'd0);
   endtask

   // Single-beat transaction on the 64-bit instance, expected beat is {w1, w0}.
   task automatic run_single(input logic [7:0] id, input logic [31:0] w0, input logic [31:0] w1);
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd0; a_id = id; a_bready = 1'b1;
      @(negedge clk_i); a_start = 1'b0; a_wvalid = 1'b1; a_wdata = w0; #1;
      check("single idle_in_pack", {63'd0, a_idle}, 64'd0);
      check("single wready0", {63'd0, a_wready}, 64'd1);
      @(negedge clk_i); a_wdata = w1; #1;
      check("single wready1", {63'd0, a_wready}, 64'd1);
      check("single bvalid_early", {63'd0, a_bvalid}, 64'd0);
      @(negedge clk_i); a_wvalid = 1'b0; #1;
      check("single bvalid", {63'd0, a_bvalid}, 64'd1);
      check("single bdata", a_bdata, {w1, w0});
      check("single bid", {56'd0, a_bid}, {56'd0, id});
      check("single blast", {63'd0, a_blast}, 64'd1);
      check("single done", {63'd0, a_done}, 64'd1);
      check("single wready_drain", {63'd0, a_wready}, 64'd0);
      $display("single beat id=%0h data=%016h", a_bid, a_bdata);
      @(negedge clk_i); #1;
      check("single idle_after", {63'd0, a_idle}, 64'd1);
      check("single bvalid_after", {63'd0, a_bvalid}, 64'd0);
      check("single done_after", {63'd0, a_done}, 64'd0);
   endtask

   initial begin
      logic [31:0] w [8];

      // Reset state
      @(negedge clk_i); @(negedge clk_i); #1;
      check_a_reset("reset");
      check("reset b_idle", {63'd0, b_idle}, 64'd1);
      @(negedge clk_i); rst_ni = 1'b1;

      // Single beat, len=0
      run_single(8'h5A, 32'h11111111, 32'h22222222);

      // len=3, four back-to-back beats at full rate
      for (int i = 0; i < 8; i++) w[i] = 32'hA000_0000 + 32'(i);
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd3; a_id = 8'h77; a_bready = 1'b1;
      @(negedge clk_i); a_start = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            a_wvalid = 1'b1; a_wdata = w[i];
         end else begin
            a_wvalid = 1'b0;
         end
         #1;
         if (i < 8) check("b2b wready", {63'd0, a_wready}, 64'd1);
         if (i >= 2 && (i % 2) == 0) begin
            check("b2b bvalid", {63'd0, a_bvalid}, 64'd1);
            check("b2b bdata", a_bdata, {w[i-1], w[i-2]});
            check("b2b bid", {56'd0, a_bid}, 64'h77);
            check("b2b blast", {63'd0, a_blast}, (i == 8) ? 64'd1 : 64'd0);
            check("b2b done", {63'd0, a_done}, (i == 8) ? 64'd1 : 64'd0);
            $display("b2b beat %0d data=%016h last=%0b", i/2 - 1, a_bdata, a_blast);
         end else begin
            check("b2b bvalid_gap", {63'd0, a_bvalid}, 64'd0);
         end
         @(negedge clk_i);
      end
      #1; check("b2b idle_after", {63'd0, a_idle}, 64'd1);

      // len=1 with downstream backpressure for 5 cycles
      for (int i = 0; i < 4; i++) w[i] = 32'hB000_0000 + 32'(i);
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd1; a_id = 8'h3C; a_bready = 1'b1;
      @(negedge clk_i); a_start = 1'b0; a_wvalid = 1'b1; a_wdata = w[0];
      @(negedge clk_i); a_wdata = w[1];
      @(negedge clk_i); a_wdata = w[2]; a_bready = 1'b0; #1;
      check("bp first bvalid", {63'd0, a_bvalid}, 64'd1);
      check("bp first bdata", a_bdata, {w[1], w[0]});
      check("bp first blast", {63'd0, a_blast}, 64'd0);
      check("bp wready_idx0", {63'd0, a_wready}, 64'd1);
      for (int c = 3; c <= 6; c++) begin
         @(negedge clk_i); a_wdata = w[3]; #1;
         check("bp wready_stall", {63'd0, a_wready}, 64'd0);
         check("bp hold bvalid", {63'd0, a_bvalid}, 64'd1);
         check("bp hold bdata", a_bdata, {w[1], w[0]});
      end
      @(negedge clk_i); a_bready = 1'b1; #1;
      check("bp wready_release", {63'd0, a_wready}, 64'd1);
      check("bp release bdata", a_bdata, {w[1], w[0]});
      $display("bp beat 0 data=%016h", a_bdata);
      @(negedge clk_i); a_wvalid = 1'b0; #1;
      check("bp second bvalid", {63'd0, a_bvalid}, 64'd1);
      check("bp second bdata", a_bdata, {w[3], w[2]});
      check("bp second blast", {63'd0, a_blast}, 64'd1);
      check("bp done", {63'd0, a_done}, 64'd1);
      $display("bp beat 1 data=%016h", a_bdata);
      @(negedge clk_i); #1;
      check("bp idle_after", {63'd0, a_idle}, 64'd1);

      // start_i during PACK is ignored
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd0; a_id = 8'h44;
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd5; a_id = 8'h33;
      a_wvalid = 1'b1; a_wdata = 32'hC0C0C0C0;
      @(negedge clk_i); a_start = 1'b0; a_wdata = 32'hD1D1D1D1;
      @(negedge clk_i); a_wvalid = 1'b0; #1;
      check("ign bid", {56'd0, a_bid}, 64'h44);
      check("ign blast", {63'd0, a_blast}, 64'd1);
      check("ign bdata", a_bdata, 64'hD1D1D1D1_C0C0C0C0);
      check("ign done", {63'd0, a_done}, 64'd1);
      check("ign err", {63'd0, a_err}, {63'd0, ERR_EXP});
      $display("ignored-start beat id=%0h data=%016h", a_bid, a_bdata);
      @(negedge clk_i); #1;
      check("ign err_sticky", {63'd0, a_err}, {63'd0, ERR_EXP});
      check("ign idle_after", {63'd0, a_idle}, 64'd1);

      // Asynchronous reset after 3 words of a len=3 transfer
      @(negedge clk_i); a_start = 1'b1; a_len = 8'd3; a_id = 8'h21;
      @(negedge clk_i); a_start = 1'b0; a_wvalid = 1'b1; a_wdata = 32'hE0;
      @(negedge clk_i); a_wdata = 32'hE1;
      @(negedge clk_i); a_wdata = 32'hE2;
      @(negedge clk_i); a_wvalid = 1'b0; #1;
      check("mid idle_busy", {63'd0, a_idle}, 64'd0);
      rst_ni = 1'b0; #1;
      check_a_reset("midrst");
      $display("mid-transfer reset applied");
      @(negedge clk_i); rst_ni = 1'b1;
      run_single(8'h99, 32'hCAFE0001, 32'hBEEF0002);

      // MEM_DW=32 instance, len=2: each word is one beat
      @(negedge clk_i); b_start = 1'b1; b_len = 8'd2; b_id = 8'h0F; b_bready = 1'b1;
      @(negedge clk_i); b_start = 1'b0; b_wvalid = 1'b1; b_wdata = 32'h0000_F001; #1;
      check("r1 wready0", {63'd0, b_wready}, 64'd1);
      check("r1 bvalid0", {63'd0, b_bvalid}, 64'd0);
      @(negedge clk_i); b_wdata = 32'h0000_F002; #1;
      check("r1 beat0", {32'd0, b_bdata}, 64'h0000_F001);
      check("r1 last0", {63'd0, b_blast}, 64'd0);
      check("r1 wready1", {63'd0, b_wready}, 64'd1);
      @(negedge clk_i); b_wdata = 32'h0000_F003; #1;
      check("r1 beat1", {32'd0, b_bdata}, 64'h0000_F002);
      check("r1 last1", {63'd0, b_blast}, 64'd0);
      @(negedge clk_i); b_wvalid = 1'b0; #1;
      check("r1 beat2", {32'd0, b_bdata}, 64'h0000_F003);
      check("r1 last2", {63'd0, b_blast}, 64'd1);
      check("r1 bid", {56'd0, b_bid}, 64'h0F);
      check("r1 done", {63'd0, b_done}, 64'd1);
      $display("ratio1 last beat data=%08h", b_bdata);
      @(negedge clk_i); #1;
      check("r1 idle_after", {63'd0, b_idle}, 64'd1);

      // Synchronous clear drops a pending beat without done_o
      @(negedge clk_i); b_start = 1'b1; b_len = 8'd0; b_id = 8'h01; b_bready = 1'b0;
      @(negedge clk_i); b_start = 1'b0; b_wvalid = 1'b1; b_wdata = 32'h1234_5678;
      @(negedge clk_i); b_wvalid = 1'b0; #1;
      check("clr pending bvalid", {63'd0, b_bvalid}, 64'd1);
      clear_i = 1'b1;
      @(negedge clk_i); clear_i = 1'b0; #1;
      check("clr bvalid", {63'd0, b_bvalid}, 64'd0);
      check("clr bdata", {32'd0, b_bdata}, 64'd0);
      check("clr idle", {63'd0, b_idle}, 64'd1);
      check("clr done", {63'd0, b_done}, 64'd0);
      $display("clear applied to 32-bit instance");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
